key_scan_ctrl: RTL and testbench

KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

---
 rtl/key_scan_ctrl_if.sv | 21 ++
 rtl/key_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_scan_ctrl_if.sv
// Key event stream: one FIFO head entry offered per cycle with valid/ready handshake.
interface key_scan_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_code;
  logic       evt_press;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_press,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_press,
    output evt_ready
  );
endinterface

// File: rtl/key_scan_ctrl.sv
// 4x4 key matrix scanner: row drive, column sync, scan-level debounce,
// per-key press/release event generation into a 4-entry FIFO.
module key_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 12000,
  parameter int unsigned DEB_SCANS = 4
) (
  input  logic                  clk_12m,
  input  logic                  rst,
  output logic [3:0]            row_out,
  input  logic [3:0]            col_in,
  key_scan_ctrl_if.master       evt,
  output logic                  overflow
);

  localparam int unsigned TMR_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned STB_W      = (DEB_SCANS > 0) ? $clog2(DEB_SCANS + 1) : 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_SCAN = 2'd0,
    ST_CMP  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       press;
    logic [3:0] code;
  } evt_t;

  state_t           state_q, state_d;
  logic [3:0]       col_s1_q, col_s2_q;
  logic [3:0]       row_out_q, row_out_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [TMR_W-1:0] row_tmr_q, row_tmr_d;
  logic [15:0]      snap_q, snap_d;
  logic [15:0]      prev_q, prev_d;
  logic [15:0]      deb_q, deb_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [3:0]       emit_idx_q, emit_idx_d;
  evt_t             fifo_q [FIFO_DEPTH];
  evt_t             fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;

  logic             push_req;
  evt_t             push_ent;
  logic             pop;
  logic             full;
  logic             push_ok;

  // Scan sequencing, debounce compare and per-key event emission.
  always_comb begin
    state_d    = state_q;
    row_out_d  = row_out_q;
    row_idx_d  = row_idx_q;
    row_tmr_d  = row_tmr_q;
    snap_d     = snap_q;
    prev_d     = prev_q;
    deb_d      = deb_q;
    stable_d   = stable_q;
    emit_idx_d = emit_idx_q;
    push_req   = 1'b0;
    push_ent   = '0;

    case (state_q)
      ST_SCAN: begin
        if (row_tmr_q == TMR_W'(SCAN_DIV - 1)) begin
          row_tmr_d = '0;
          snap_d[{row_idx_q, 2'b00} +: 4] = ~col_s2_q;
          row_idx_d = row_idx_q + 2'd1;
          row_out_d = {row_out_q[2:0], row_out_q[3]};
          if (row_idx_q == 2'd3) begin
            state_d = ST_CMP;
          end
        end else begin
          row_tmr_d = row_tmr_q + TMR_W'(1);
        end
      end

      ST_CMP: begin
        prev_d  = snap_q;
        state_d = ST_SCAN;
        if (snap_q == prev_q) begin
          if (stable_q != STB_W'(DEB_SCANS)) begin
            stable_d = stable_q + STB_W'(1);
          end
          // Only the transition into saturation may trigger an emit pass.
          if ((stable_q == STB_W'(DEB_SCANS - 1)) && (snap_q != deb_q)) begin
            state_d    = ST_EMIT;
            emit_idx_d = '0;
          end
        end else begin
          stable_d = '0;
        end
      end

      ST_EMIT: begin
        if (snap_q[emit_idx_q] != deb_q[emit_idx_q]) begin
          push_req            = 1'b1;
          push_ent.press      = snap_q[emit_idx_q];
          push_ent.code       = emit_idx_q;
          deb_d[emit_idx_q]   = snap_q[emit_idx_q];
        end
        emit_idx_d = emit_idx_q + 4'd1;
        if (emit_idx_q == 4'd15) begin
          state_d = ST_SCAN;
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  // Event FIFO: push from the emitter, pop on handshake, drop when full without a pop.
  always_comb begin
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    pop        = (cnt_q != '0) && evt.evt_ready;
    full       = (cnt_q == CNT_W'(FIFO_DEPTH));
    push_ok    = push_req && (!full || pop);
    overflow_d = push_req && !push_ok;

    if (push_ok) begin
      fifo_d[wptr_q] = push_ent;
      wptr_d         = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // State register for the whole block; column inputs pass through a two-flop synchroniser.
  always_ff @(posedge clk_12m or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      col_s1_q   <= 4'hF;
      col_s2_q   <= 4'hF;
      row_out_q  <= 4'b1110;
      row_idx_q  <= '0;
      row_tmr_q  <= '0;
      snap_q     <= '0;
      prev_q     <= '0;
      deb_q      <= '0;
      stable_q   <= '0;
      emit_idx_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_s1_q   <= col_in;
      col_s2_q   <= col_s1_q;
      row_out_q  <= row_out_d;
      row_idx_q  <= row_idx_d;
      row_tmr_q  <= row_tmr_d;
      snap_q     <= snap_d;
      prev_q     <= prev_d;
      deb_q      <= deb_d;
      stable_q   <= stable_d;
      emit_idx_q <= emit_idx_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign row_out       = row_out_q;
  assign overflow      = overflow_q;
  assign evt.evt_valid = (cnt_q != '0);
  assign evt.evt_code  = fifo_q[rptr_q].code;
  assign evt.evt_press = fifo_q[rptr_q].press;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl with a key-matrix model and an expected-event scoreboard.
module tb_key_scan_ctrl;

  typedef struct packed {
    logic       press;
    logic [3:0] code;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic        overflow;
  logic [15:0] keys;

  key_scan_ctrl_if evt ();

  key_scan_ctrl #(
    .SCAN_DIV  (4),
    .DEB_SCANS (2)
  ) dut (
    .clk_12m  (clk),
    .rst      (rst),
    .row_out  (row_out),
    .col_in   (col_in),
    .evt      (evt),
    .overflow (overflow)
  );

  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   evt_seen = 0;
  int   ovf_cnt  = 0;
  int   pop_cyc [$];
  exp_t exp_q   [$];
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Matrix model: a closed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_out[r]) col_in = col_in & ~keys[r*4 +: 4];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && overflow) ovf_cnt++;
    if (!rst && evt.evt_valid && evt.evt_ready) begin
      evt_seen++;
      pop_cyc.push_back(cyc);
      chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("evt_code", 32'(evt.evt_code), 32'(mon_e.code));
        chk("evt_press", 32'(evt.evt_press), 32'(mon_e.press));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input logic press, input logic [3:0] code);
    exp_t e;
    e.press = press;
    e.code  = code;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step(1);
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int pc;
    int pushes;
    bit found;

    rst = 1'b1;
    keys = '0;
    evt.evt_ready = 1'b0;
    step(3);

    // Reset values
    chk("rst_row_out", 32'(row_out), 32'hE);
    chk("rst_evt_valid", 32'(evt.evt_valid), 32'd0);
    chk("rst_evt_code", 32'(evt.evt_code), 32'd0);
    chk("rst_evt_press", 32'(evt.evt_press), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Single held key then its release
    evt.evt_ready = 1'b1;
    base = evt_seen;
    keys[6] = 1'b1;
    expect_evt(1'b1, 4'd6);
    drain("k6_press");
    step(40);
    chk("k6_press_count", 32'(evt_seen - base), 32'd1);
    base = evt_seen;
    keys[6] = 1'b0;
    expect_evt(1'b0, 4'd6);
    drain("k6_release");
    step(40);
    chk("k6_release_count", 32'(evt_seen - base), 32'd1);

    // Bouncing key never becomes stable
    base = evt_seen;
    for (int i = 0; i < 40; i++) begin
      keys[6] = ~keys[6];
      step(5);
    end
    keys[6] = 1'b0;
    step(120);
    chk("bounce_no_events", 32'(evt_seen - base), 32'd0);

    // Simultaneous keys emitted in index order, one index per EMIT cycle
    pc = pop_cyc.size();
    keys = 16'h8021;
    expect_evt(1'b1, 4'd0);
    expect_evt(1'b1, 4'd5);
    expect_evt(1'b1, 4'd15);
    drain("multi_press");
    chk("multi_count", 32'(pop_cyc.size() - pc), 32'd3);
    if (pop_cyc.size() - pc == 3) begin
      chk("multi_gap_0_5", 32'(pop_cyc[pc+1] - pop_cyc[pc]), 32'd5);
      chk("multi_gap_5_15", 32'(pop_cyc[pc+2] - pop_cyc[pc+1]), 32'd10);
    end
    keys = '0;
    expect_evt(1'b0, 4'd0);
    expect_evt(1'b0, 4'd5);
    expect_evt(1'b0, 4'd15);
    drain("multi_release");

    // Overflow with consumer stalled: 6 events into 4 slots
    evt.evt_ready = 1'b0;
    base = ovf_cnt;
    keys = 16'h000E;
    expect_evt(1'b1, 4'd1);
    expect_evt(1'b1, 4'd2);
    expect_evt(1'b1, 4'd3);
    step(100);
    keys = '0;
    expect_evt(1'b0, 4'd1);
    step(100);
    chk("ovf_pulses", 32'(ovf_cnt - base), 32'd2);
    chk("ovf_valid", 32'(evt.evt_valid), 32'd1);
    chk("ovf_head_code", 32'(evt.evt_code), 32'd1);
    chk("ovf_head_press", 32'(evt.evt_press), 32'd1);
    step(10);
    chk("ovf_head_code_hold", 32'(evt.evt_code), 32'd1);
    chk("ovf_head_press_hold", 32'(evt.evt_press), 32'd1);

    // Push into a full FIFO on a pop cycle is accepted
    base = ovf_cnt;
    keys[15] = 1'b1;
    expect_evt(1'b1, 4'd15);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (dut.push_req) begin
        evt.evt_ready = 1'b1;
        found = 1'b1;
        break;
      end
    end
    chk("full_push_seen", 32'(found), 32'd1);
    step(1);
    evt.evt_ready = 1'b0;
    chk("full_push_no_ovf", 32'(overflow), 32'd0);
    step(5);
    chk("full_push_ovf_count", 32'(ovf_cnt - base), 32'd0);
    base = evt_seen;
    evt.evt_ready = 1'b1;
    drain("full_drain");
    chk("full_occupancy", 32'(evt_seen - base), 32'd4);
    keys[15] = 1'b0;
    expect_evt(1'b0, 4'd15);
    drain("k15_release");

    // Reset in the middle of EMIT with two entries queued
    evt.evt_ready = 1'b0;
    keys = 16'h0208;
    pushes = 0;
    for (int i = 0; i < 200 && pushes < 2; i++) begin
      step(1);
      if (dut.push_req) pushes++;
    end
    chk("rst_emit_pushes", 32'(pushes), 32'd2);
    step(1);
    chk("rst_emit_queued", 32'(evt.evt_valid), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_emit_valid", 32'(evt.evt_valid), 32'd0);
    chk("rst_emit_row_out", 32'(row_out), 32'hE);
    step(2);
    rst = 1'b0;
    base = cyc;
    pc = pop_cyc.size();
    evt.evt_ready = 1'b1;
    expect_evt(1'b1, 4'd3);
    expect_evt(1'b1, 4'd9);
    drain("rst_repress");
    if (pop_cyc.size() > pc) begin
      chk("rst_repress_latency",
          32'((pop_cyc[pc] - base >= 48) && (pop_cyc[pc] - base <= 3*17 + 20)), 32'd1);
    end
    keys = '0;
    expect_evt(1'b0, 4'd3);
    expect_evt(1'b0, 4'd9);
    drain("rst_release");
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
